id_ex_hazard_stage: RTL and testbench

- ID/EX pipeline register plus load-use hazard control for the lc3b pipeline.
- Captures decoded ID fields each cycle and presents them as the registered id_ex_* signals consumed by the EX stage and the forwarding unit.
- Detects a load followed by a dependent instruction, inserts exactly one bubble into ID/EX, and holds PC and IF/ID.
- Honours a global memory freeze and a branch flush; counts load-use stalls for performance reporting.

---
 rtl/id_ex_hazard_stage.sv | 100 ++++++++++
 tb/tb_id_ex_hazard_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register for the lc3b pipeline with load-use hazard detection.
// A load in EX followed by a dependent instruction in ID costs one bubble while
// PC and IF/ID are held; memory freeze and branch flush take priority.
module id_ex_hazard_stage #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [2:0]       id_sr1,
   input  logic [2:0]       id_sr2,
   input  logic [2:0]       id_dr,
   input  logic             id_uses_sr1,
   input  logic             id_uses_sr2,
   input  logic             id_regwrite,
   input  logic             id_in_ld,
   input  logic             id_in_st,
   input  logic             id_in_lea,
   input  logic             id_set_r7,
   input  logic             mem_stall,
   input  logic             flush,
   output logic             id_ex_valid,
   output logic [2:0]       id_ex_sr1,
   output logic [2:0]       id_ex_sr2,
   output logic [2:0]       id_ex_dr,
   output logic             id_ex_regwrite,
   output logic             id_ex_in_ld,
   output logic             id_ex_in_st,
   output logic             id_ex_in_lea,
   output logic             id_ex_set_r7,
   output logic             hold,
   output logic [CNT_W-1:0] ld_use_stalls
);

   localparam int unsigned REG_W = 3;

   logic dep_sr1;
   logic dep_sr2;
   logic dep_st;
   logic hazard;
   logic load_bubble;
   logic cnt_inc;
   logic cnt_sat;

   // Load-use detection against the load currently in EX, and the resulting hold.
   always_comb begin
      dep_sr1     = id_uses_sr1 && (id_sr1 == id_ex_dr);
      dep_sr2     = id_uses_sr2 && (id_sr2 == id_ex_dr);
      dep_st      = id_in_st    && (id_dr  == id_ex_dr);
      hazard      = id_valid && id_ex_valid && id_ex_in_ld && id_ex_regwrite &&
                    (dep_sr1 || dep_sr2 || dep_st);
      hold        = mem_stall || (hazard && !flush);
      // Flush, hazard and an empty ID slot all present a bubble to EX.
      load_bubble = flush || hazard || !id_valid;
      cnt_sat     = (ld_use_stalls == {CNT_W{1'b1}});
      cnt_inc     = hazard && !flush && !cnt_sat;
   end

   // ID/EX register and stall counter; a memory freeze holds everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         id_ex_valid    <= 1'b0;
         id_ex_sr1      <= REG_W'(0);
         id_ex_sr2      <= REG_W'(0);
         id_ex_dr       <= REG_W'(0);
         id_ex_regwrite <= 1'b0;
         id_ex_in_ld    <= 1'b0;
         id_ex_in_st    <= 1'b0;
         id_ex_in_lea   <= 1'b0;
         id_ex_set_r7   <= 1'b0;
         ld_use_stalls  <= CNT_W'(0);
      end else if (!mem_stall) begin
         if (load_bubble) begin
            id_ex_valid    <= 1'b0;
            id_ex_sr1      <= REG_W'(0);
            id_ex_sr2      <= REG_W'(0);
            id_ex_dr       <= REG_W'(0);
            id_ex_regwrite <= 1'b0;
            id_ex_in_ld    <= 1'b0;
            id_ex_in_st    <= 1'b0;
            id_ex_in_lea   <= 1'b0;
            id_ex_set_r7   <= 1'b0;
         end else begin
            id_ex_valid    <= 1'b1;
            id_ex_sr1      <= id_sr1;
            id_ex_sr2      <= id_sr2;
            id_ex_dr       <= id_dr;
            id_ex_regwrite <= id_regwrite;
            id_ex_in_ld    <= id_in_ld;
            id_ex_in_st    <= id_in_st;
            id_ex_in_lea   <= id_in_lea;
            id_ex_set_r7   <= id_set_r7;
         end
         if (cnt_inc) begin
            ld_use_stalls <= ld_use_stalls + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed self-checking bench for id_ex_hazard_stage (counter width 4).
module tb_id_ex_hazard_stage;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic [2:0]       id_sr1, id_sr2, id_dr;
   logic             id_uses_sr1, id_uses_sr2, id_regwrite;
   logic             id_in_ld, id_in_st, id_in_lea, id_set_r7;
   logic             mem_stall, flush;
   logic             id_ex_valid;
   logic [2:0]       id_ex_sr1, id_ex_sr2, id_ex_dr;
   logic             id_ex_regwrite, id_ex_in_ld, id_ex_in_st, id_ex_in_lea, id_ex_set_r7;
   logic             hold;
   logic [CNT_W-1:0] ld_use_stalls;

   int n_cmp = 0;
   int n_err = 0;

   id_ex_hazard_stage #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2), .id_dr(id_dr),
      .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2), .id_regwrite(id_regwrite),
      .id_in_ld(id_in_ld), .id_in_st(id_in_st), .id_in_lea(id_in_lea), .id_set_r7(id_set_r7),
      .mem_stall(mem_stall), .flush(flush),
      .id_ex_valid(id_ex_valid), .id_ex_sr1(id_ex_sr1), .id_ex_sr2(id_ex_sr2), .id_ex_dr(id_ex_dr),
      .id_ex_regwrite(id_ex_regwrite), .id_ex_in_ld(id_ex_in_ld), .id_ex_in_st(id_ex_in_st),
      .id_ex_in_lea(id_ex_in_lea), .id_ex_set_r7(id_ex_set_r7),
      .hold(hold), .ld_use_stalls(ld_use_stalls)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_valid = 0; id_sr1 = 0; id_sr2 = 0; id_dr = 0;
      id_uses_sr1 = 0; id_uses_sr2 = 0; id_regwrite = 0;
      id_in_ld = 0; id_in_st = 0; id_in_lea = 0; id_set_r7 = 0;
      mem_stall = 0; flush = 0;
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   // LDR Rdr, [Rbase]
   task automatic drive_load(input logic [2:0] dr, input logic [2:0] base);
      clear_in();
      id_valid = 1; id_in_ld = 1; id_regwrite = 1; id_dr = dr;
      id_uses_sr1 = 1; id_sr1 = base;
   endtask

   // ADD Rdr, Ra, Rb
   task automatic drive_add(input logic [2:0] dr, input logic [2:0] a, input logic [2:0] b);
      clear_in();
      id_valid = 1; id_regwrite = 1; id_dr = dr;
      id_uses_sr1 = 1; id_sr1 = a; id_uses_sr2 = 1; id_sr2 = b;
   endtask

   task automatic test_reset();
      rst_n = 0;
      id_valid = 1; id_sr1 = 3'($urandom); id_sr2 = 3'($urandom); id_dr = 3'($urandom);
      id_uses_sr1 = 1; id_uses_sr2 = 1; id_regwrite = 1; id_in_ld = 1;
      id_in_st = 1; id_in_lea = 1; id_set_r7 = 1; mem_stall = 0; flush = 0;
      tick();
      tick();
      n_cmp++; if ({id_ex_valid, id_ex_regwrite, id_ex_in_ld, id_ex_in_st, id_ex_in_lea, id_ex_set_r7} !== 6'b0) begin
         n_err++; $display("FAIL reset_flags: got %b expected 000000", {id_ex_valid, id_ex_regwrite, id_ex_in_ld, id_ex_in_st, id_ex_in_lea, id_ex_set_r7}); end
      n_cmp++; if ({id_ex_sr1, id_ex_sr2, id_ex_dr} !== 9'd0) begin
         n_err++; $display("FAIL reset_regs: got %h expected 0", {id_ex_sr1, id_ex_sr2, id_ex_dr}); end
      n_cmp++; if (hold !== 1'b0) begin n_err++; $display("FAIL reset_hold: got %b expected 0", hold); end
      n_cmp++; if (ld_use_stalls !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", ld_use_stalls); end
      rst_n = 1;
      clear_in();
      id_valid = 1; id_sr1 = 3; id_regwrite = 1;
      tick();
      n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_sr1 !== 3'd3 || id_ex_regwrite !== 1'b1) begin
         n_err++; $display("FAIL reset_release: got v=%b sr1=%0d rw=%b expected v=1 sr1=3 rw=1", id_ex_valid, id_ex_sr1, id_ex_regwrite); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive_load(3'd2, 3'd5);
      tick();
      drive_add(3'd3, 3'd2, 3'd1);
      #1;
      n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL lu_hold: got %b expected 1", hold); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b0 || id_ex_dr !== 3'd0 || id_ex_regwrite !== 1'b0) begin
         n_err++; $display("FAIL lu_bubble: got v=%b dr=%0d rw=%b expected 0 0 0", id_ex_valid, id_ex_dr, id_ex_regwrite); end
      n_cmp++; if (hold !== 1'b0) begin n_err++; $display("FAIL lu_hold_clear: got %b expected 0", hold); end
      n_cmp++; if (ld_use_stalls !== 4'd1) begin n_err++; $display("FAIL lu_cnt: got %0d expected 1", ld_use_stalls); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_dr !== 3'd3 || id_ex_sr1 !== 3'd2 || id_ex_sr2 !== 3'd1 || id_ex_in_ld !== 1'b0) begin
         n_err++; $display("FAIL lu_capture: got v=%b dr=%0d sr1=%0d sr2=%0d ld=%b expected 1 3 2 1 0", id_ex_valid, id_ex_dr, id_ex_sr1, id_ex_sr2, id_ex_in_ld); end
   endtask

   task automatic test_store_data();
      do_reset();
      drive_load(3'd4, 3'd1);
      tick();
      clear_in();
      id_valid = 1; id_in_st = 1; id_dr = 4; id_uses_sr1 = 1; id_sr1 = 6;
      #1;
      n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL st_hold: got %b expected 1", hold); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b0 || ld_use_stalls !== 4'd1) begin
         n_err++; $display("FAIL st_bubble: got v=%b cnt=%0d expected v=0 cnt=1", id_ex_valid, ld_use_stalls); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_in_st !== 1'b1 || id_ex_dr !== 3'd4) begin
         n_err++; $display("FAIL st_capture: got v=%b st=%b dr=%0d expected 1 1 4", id_ex_valid, id_ex_in_st, id_ex_dr); end
      drive_load(3'd4, 3'd1);
      tick();
      clear_in();
      id_valid = 1; id_in_st = 1; id_dr = 5; id_uses_sr1 = 1; id_sr1 = 6;
      #1;
      n_cmp++; if (hold !== 1'b0) begin n_err++; $display("FAIL st_nodep_hold: got %b expected 0", hold); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_dr !== 3'd5 || ld_use_stalls !== 4'd1) begin
         n_err++; $display("FAIL st_nodep: got v=%b dr=%0d cnt=%0d expected 1 5 1", id_ex_valid, id_ex_dr, ld_use_stalls); end
   endtask

   task automatic test_flush();
      do_reset();
      drive_load(3'd0, 3'd1);
      tick();
      drive_add(3'd6, 3'd0, 3'd7);
      flush = 1;
      #1;
      n_cmp++; if (hold !== 1'b0) begin n_err++; $display("FAIL fl_hold: got %b expected 0", hold); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b0 || id_ex_regwrite !== 1'b0 || ld_use_stalls !== 4'd0) begin
         n_err++; $display("FAIL fl_bubble: got v=%b rw=%b cnt=%0d expected 0 0 0", id_ex_valid, id_ex_regwrite, ld_use_stalls); end
      flush = 0;
      tick();
      n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_dr !== 3'd6) begin
         n_err++; $display("FAIL fl_after: got v=%b dr=%0d expected 1 6", id_ex_valid, id_ex_dr); end
   endtask

   task automatic test_mem_freeze();
      do_reset();
      drive_load(3'd2, 3'd3);
      tick();
      drive_add(3'd5, 3'd1, 3'd2);
      mem_stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL mf_hold[%0d]: got %b expected 1", i, hold); end
         tick();
         n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_in_ld !== 1'b1 || id_ex_dr !== 3'd2 || ld_use_stalls !== 4'd0) begin
            n_err++; $display("FAIL mf_frozen[%0d]: got v=%b ld=%b dr=%0d cnt=%0d expected 1 1 2 0", i, id_ex_valid, id_ex_in_ld, id_ex_dr, ld_use_stalls); end
      end
      mem_stall = 0;
      #1;
      n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL mf_release_hold: got %b expected 1", hold); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b0 || ld_use_stalls !== 4'd1) begin
         n_err++; $display("FAIL mf_bubble: got v=%b cnt=%0d expected 0 1", id_ex_valid, ld_use_stalls); end
      tick();
      n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_dr !== 3'd5 || ld_use_stalls !== 4'd1) begin
         n_err++; $display("FAIL mf_capture: got v=%b dr=%0d cnt=%0d expected 1 5 1", id_ex_valid, id_ex_dr, ld_use_stalls); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive_load(3'd1, 3'd0);
      tick();
      drive_load(3'd2, 3'd1);
      #1;
      n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL b2b_hold1: got %b expected 1", hold); end
      tick();
      tick();
      n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_in_ld !== 1'b1 || id_ex_dr !== 3'd2 || ld_use_stalls !== 4'd1) begin
         n_err++; $display("FAIL b2b_load2: got v=%b ld=%b dr=%0d cnt=%0d expected 1 1 2 1", id_ex_valid, id_ex_in_ld, id_ex_dr, ld_use_stalls); end
      drive_add(3'd3, 3'd4, 3'd2);
      #1;
      n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL b2b_hold2: got %b expected 1", hold); end
      tick();
      tick();
      n_cmp++; if (id_ex_valid !== 1'b1 || id_ex_dr !== 3'd3 || ld_use_stalls !== 4'd2) begin
         n_err++; $display("FAIL b2b_add: got v=%b dr=%0d cnt=%0d expected 1 3 2", id_ex_valid, id_ex_dr, ld_use_stalls); end
   endtask

   task automatic test_saturation();
      logic [CNT_W-1:0] exp_cnt;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive_load(3'd1, 3'd0);
         tick();
         drive_add(3'd2, 3'd1, 3'd3);
         tick();
         exp_cnt = (i >= 14) ? 4'd15 : 4'(i + 1);
         if (i == 13 || i == 14 || i == 16) begin
            n_cmp++; if (ld_use_stalls !== exp_cnt) begin
               n_err++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, ld_use_stalls, exp_cnt); end
         end
      end
      drive_load(3'd1, 3'd0);
      tick();
      rst_n = 0;
      tick();
      n_cmp++; if (ld_use_stalls !== 4'd0 || id_ex_valid !== 1'b0 || id_ex_in_ld !== 1'b0) begin
         n_err++; $display("FAIL sat_reset: got cnt=%0d v=%b ld=%b expected 0 0 0", ld_use_stalls, id_ex_valid, id_ex_in_ld); end
      rst_n = 1;
      clear_in();
   endtask

   initial begin
      clear_in();
      rst_n = 0;
      #2;
      test_reset();
      test_load_use();
      test_store_data();
      test_flush();
      test_mem_freeze();
      test_back_to_back();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
